// File: rtl/hybrid_pwm_sd_mc.sv
// Multi-channel hybrid PWM / first-order sigma-delta audio DAC with a shared scaling multiplier,
// anti-pop ramp FSM and periodic fraction dump. Define HYBRID_PWM_SD_DITHER_EN for LFSR dump dither.
module hybrid_pwm_sd_mc #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DW        = 16,
  parameter int unsigned PWM_BITS  = 5,
  parameter int unsigned DUMP_BITS = 8,
  parameter int unsigned RAMP_BITS = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   terminate,
  input  logic                   fmt_signed,
  input  logic [CHANNELS*DW-1:0] d,
  output logic [CHANNELS-1:0]    q,
  output logic                   ready,
  output logic                   done,
  output logic [CHANNELS-1:0]    sample_stb
);

  localparam int unsigned F  = DW - PWM_BITS;
  localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PWM_BITS-1:0]  CntMax   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]  ThrInit  = CntMax - 1'b1;
  localparam logic [F-1:0]         FracHalf = {1'b1, {(F-1){1'b0}}};
  localparam logic [DW:0]          IncBias  = {{PWM_BITS{1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic [RAMP_BITS-1:0] RampMax  = {RAMP_BITS{1'b1}};
  localparam logic [RAMP_BITS-1:0] RampHalf = {1'b1, {(RAMP_BITS-1){1'b0}}};
  localparam logic [RAMP_BITS-1:0] RampInit = {{5{1'b1}}, {(RAMP_BITS-5){1'b0}}};

  localparam logic [1:0] StRampUp = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StTerm   = 2'd2;
  localparam logic [1:0] StHalt   = 2'd3;

  logic [PWM_BITS-1:0]    cnt_q;
  logic                   wrap;
  logic                   run;
  logic [SW-1:0]          sel_q;
  logic [SW-1:0]          sel_nxt;
  logic [SW-1:0]          src_q;
  logic                   inc_vld_q;
  logic [DW-1:0]          inc_q;
  logic [DW-1:0]          inc_d;
  logic [DW-1:0]          d_sel;
  logic [DW-1:0]          x;
  logic [DW+PWM_BITS-1:0] prod;
  logic [DW-1:0]          scaled;
  logic [DW-1:0]          s;
  logic [DUMP_BITS-1:0]   dump_cnt_q;
  logic                   dump_q;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [RAMP_BITS-1:0]   r_q;
  logic [RAMP_BITS-1:0]   r_d;

  // The integer part of sigma is exactly thr, so only the fraction is kept per channel.
  logic [PWM_BITS-1:0] thr_q     [CHANNELS];
  logic [F-1:0]        frac_q    [CHANNELS];
  logic [F-1:0]        dump_frac [CHANNELS];

  assign wrap  = (cnt_q == CntMax);
  assign run   = (state_q == StRun);
  assign ready = run;
  assign done  = (state_q == StHalt);

  // Shared stage-1 datapath: one multiplier serves the channel at sel_q.
  assign d_sel = d[sel_q*DW +: DW];

  always_comb begin
    x = DW'(r_q) << (DW - RAMP_BITS);
    if (run) begin
      x = d_sel ^ {fmt_signed, {(DW-1){1'b0}}};
    end
  end

  assign prod    = (DW+PWM_BITS)'(x) * (DW+PWM_BITS)'(ThrInit);
  assign scaled  = DW'(prod >> PWM_BITS);
  assign inc_d   = DW'({1'b0, scaled} + IncBias);
  assign s       = inc_q + DW'(frac_q[src_q]);
  assign sel_nxt = (sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;

`ifdef HYBRID_PWM_SD_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (wrap) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    logic [15:0]   rot;
    logic [DW-1:0] rot_ext;
    for (int k = 0; k < CHANNELS; k++) begin
      rot          = (lfsr_q << k) | (lfsr_q >> (16 - k));
      rot_ext      = DW'(rot);
      dump_frac[k] = rot_ext[F-1:0];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      dump_frac[k] = FracHalf;
    end
  end
`endif

  // PWM counter, outputs and stage-2 sigma-delta update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CntMax;
      q     <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        thr_q[k]  <= ThrInit;
        frac_q[k] <= FracHalf;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        if (wrap) begin
          q[k] <= 1'b1;
        end else if (cnt_q == thr_q[k]) begin
          q[k] <= 1'b0;
        end
        if (wrap && inc_vld_q && (src_q == SW'(k))) begin
          thr_q[k]  <= s[DW-1:F];
          frac_q[k] <= s[F-1:0];
        end
        if (dump_q) begin
          frac_q[k] <= dump_frac[k];
        end
      end
    end
  end

  // Stage 1; inc_vld_q blocks a stage-2 write on the first wrap, before any sample exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      src_q      <= '0;
      inc_q      <= '0;
      inc_vld_q  <= 1'b0;
      sample_stb <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        sample_stb[k] <= wrap && run && (sel_q == SW'(k));
      end
      if (wrap) begin
        inc_q     <= inc_d;
        src_q     <= sel_q;
        sel_q     <= sel_nxt;
        inc_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_cnt_q <= '0;
      dump_q     <= 1'b0;
    end else begin
      dump_q <= wrap && (dump_cnt_q == '0);
      if (wrap) begin
        dump_cnt_q <= dump_cnt_q + 1'b1;
      end
    end
  end

  // Anti-pop ramp; r only moves on dump pulses.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      StRampUp: begin
        if (dump_q) begin
          if (r_q == RampHalf) begin
            state_d = StRun;
          end else begin
            r_d = r_q - 1'b1;
            if (r_d == RampHalf) begin
              state_d = StRun;
            end
          end
        end
      end
      StRun: begin
        if (terminate) begin
          state_d = StTerm;
        end
      end
      StTerm: begin
        if (dump_q) begin
          if (r_q == RampMax) begin
            state_d = StHalt;
          end else begin
            r_d = r_q + 1'b1;
            if (r_d == RampMax) begin
              state_d = StHalt;
            end
          end
        end
      end
      StHalt: begin
        r_d = RampMax;
      end
      default: begin
        state_d = StRampUp;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRampUp;
      r_q     <= RampInit;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_hybrid_pwm_sd_mc.sv
// Directed bench for hybrid_pwm_sd_mc with a short ramp (RAMP_BITS=6) and fast dump (DUMP_BITS=1).
module tb_hybrid_pwm_sd_mc;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int P  = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             terminate;
  logic             fmt_signed;
  logic [CH*DW-1:0] d;
  logic [CH-1:0]    q;
  logic             ready;
  logic             done;
  logic [CH-1:0]    sample_stb;

  hybrid_pwm_sd_mc #(
    .CHANNELS (CH),
    .DW       (DW),
    .PWM_BITS (5),
    .DUMP_BITS(1),
    .RAMP_BITS(6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .terminate (terminate),
    .fmt_signed(fmt_signed),
    .d         (d),
    .q         (q),
    .ready     (ready),
    .done      (done),
    .sample_stb(sample_stb)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; wraps fall on edges 1, 33, 65, ...
  int ecount;
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        fmt;
    int          high0;
    int          high1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_min(input string name, input int act, input int lo);
    n_cmp++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, lo);
    end
  endtask

  task automatic wait_wrap();
    do @(negedge clk); while (ecount % P != 1);
  endtask

  // Called at the negedge right after a wrap edge; covers exactly one PWM period.
  task automatic measure(output int h0, output int h1, output int s0, output int s1);
    h0 = 0; h1 = 0; s0 = 0; s1 = 0;
    repeat (P) begin
      h0 += int'(q[0]);
      h1 += int'(q[1]);
      s0 += int'(sample_stb[0]);
      s1 += int'(sample_stb[1]);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int h0, h1, s0, s1, g0, g1, t0, t1;
    int e_term, j0, done_edge;

    // Duty = thr+1 clocks; these inputs give thr = m+1 independent of the fraction.
    vecs[0] = '{16'h8000, 16'h8000, 1'b0, 17, 17};
    vecs[1] = '{16'h0000, 16'h0000, 1'b0,  2,  2};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32, 32};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 17, 17};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1,  2,  2};
    vecs[5] = '{16'h0889, 16'h3BBC, 1'b0,  3,  9};
    vecs[6] = '{16'h5556, 16'h6667, 1'b0, 12, 14};
    vecs[7] = '{16'h7778, 16'h6EEF, 1'b0, 16, 15};
    vecs[8] = '{16'hF778, 16'h0000, 1'b0, 31,  2};
    vecs[9] = '{16'hBBBC, 16'h8889, 1'b1,  9,  3};

    reset = 1'b1; terminate = 1'b0; fmt_signed = 1'b0; d = '0;
    repeat (3) @(negedge clk);
    check("reset_q", q, 0);
    check("reset_ready", ready, 0);
    check("reset_done", done, 0);
    check("reset_stb", sample_stb, 0);

    reset = 1'b0;
    @(negedge clk);
    check("first_edge_q", q, 3);
    check("first_edge_ready", ready, 0);
    measure(h0, h1, s0, s1);
    check("first_period_high0", h0, 31);
    check("first_period_high1", h1, 31);
    check("ramp_stb0", s0, 0);
    check("ramp_stb1", s1, 0);

    while (ecount < 500) @(negedge clk);
    terminate = 1'b1;
    @(negedge clk);
    terminate = 1'b0;

    // 30th dump pulse lands on edge 2 + 64*29.
    while (ecount < 1857) @(negedge clk);
    check("ready_before_ramp_end", ready, 0);
    check("done_during_ramp", done, 0);
    @(negedge clk);
    check("ready_at_ramp_end", ready, 1);

    for (int i = 0; i < 10; i++) begin
      wait_wrap();
      d = {vecs[i].d1, vecs[i].d0};
      fmt_signed = vecs[i].fmt;
      repeat (6) wait_wrap();
      measure(h0, h1, s0, s1);
      measure(g0, g1, t0, t1);
      check($sformatf("vec%0d_high0_a", i), h0, vecs[i].high0);
      check($sformatf("vec%0d_high1_a", i), h1, vecs[i].high1);
      check($sformatf("vec%0d_high0_b", i), g0, vecs[i].high0);
      check($sformatf("vec%0d_high1_b", i), g1, vecs[i].high1);
      check($sformatf("vec%0d_stb0", i), s0 + t0, 1);
      check($sformatf("vec%0d_stb1", i), s1 + t1, 1);
    end
    check("run_done", done, 0);

    // One-clock terminate; done follows on the 31st dump after entering TERM.
    e_term = ecount;
    terminate = 1'b1;
    @(negedge clk);
    terminate = 1'b0;
    check("term_ready", ready, 0);
    j0 = 0;
    while (2 + 64 * j0 <= e_term + 1) j0++;
    done_edge = 2 + 64 * (j0 + 30);
    while (ecount < done_edge - 1) @(negedge clk);
    check("done_before_ramp_top", done, 0);
    @(negedge clk);
    check("done_at_ramp_top", done, 1);
    check("halt_ready", ready, 0);

    wait_wrap();
    measure(h0, h1, s0, s1);
    check_min("halt_high0", h0, 31);
    check_min("halt_high1", h1, 31);
    check("halt_stb", s0 + s1, 0);
    repeat (4) wait_wrap();
    check("halt_sticky_done", done, 1);
    check("halt_sticky_ready", ready, 0);

    // Asynchronous reset while q is high.
    wait_wrap();
    check("pre_reset_q", q, 3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_q", q, 0);
    check("async_reset_done", done, 0);
    check("async_reset_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rerun_first_q", q, 3);
    measure(h0, h1, s0, s1);
    check("rerun_high0", h0, 31);
    check("rerun_high1", h1, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
